ball_engine: RTL and testbench

Parametrised successor to the single-ball game engine for the Breakout display path. It owns the ball position and velocity and a ROWS x COLS brick map. On every frame tick it moves the ball, then scans the bricks one per clock for collisions, and manages serve, lives, speed-up, win and game-over. It feeds the renderer (`x_out`, `y_out`, `erase_enable`/`e_pos`) and the sound block (`play_sound1`/`play_sound2`).

---
 rtl/ball_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_ball_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Breakout ball engine: moves the ball on each frame tick, then walks the brick map
// one brick per clock looking for the first collision. Also tracks serve, lives, speed and end states.
module ball_engine #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned BALL_SIZE   = 7,
    parameter int unsigned ROWS        = 2,
    parameter int unsigned COLS        = 5,
    parameter int unsigned BLOCK_W     = 80,
    parameter int unsigned BLOCK_H     = 30,
    parameter int unsigned SPACING_X   = 40,
    parameter int unsigned FIRST_ROW_Y = 40,
    parameter int unsigned ROW_PITCH   = 50,
    parameter int unsigned PADDLE_W    = 100,
    parameter int unsigned PADDLE_Y    = 440,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned SPEEDUP_N   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick,
    input  logic       i_serve,
    input  logic [9:0] i_paddle_x,
    output logic [9:0] o_x_out,
    output logic [9:0] o_y_out,
    output logic       o_erase_enable,
    output logic [5:0] o_e_pos,
    output logic       o_play_sound1,
    output logic       o_play_sound2,
    output logic [1:0] o_lives,
    output logic       o_win,
    output logic       o_game_over
);
    localparam int unsigned NBRICKS    = ROWS * COLS;
    localparam logic [63:0] ALL_BRICKS = (NBRICKS >= 64) ? {64{1'b1}} :
                                         ((64'd1 << NBRICKS) - 64'd1);
    localparam logic [10:0] BS      = 11'(BALL_SIZE);
    localparam logic [10:0] XMAX    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0]  RESET_X = 10'(SCREEN_W / 2 - PADDLE_W / 2);
    localparam logic [9:0]  SERVE_Y = 10'(PADDLE_Y - 10);

    typedef enum logic [2:0] {StServe, StMove, StScan, StWin, StOver} state_e;

    state_e             r_state;
    logic [9:0]         r_x, r_y;
    logic signed [2:0]  r_dx, r_dy;
    logic [6:0]         r_erased;
    logic [1:0]         r_lives;
    logic [63:0]        r_bricks;
    logic [5:0]         r_k, r_row, r_col;
    logic               r_erase, r_snd1, r_snd2, r_win, r_over;
    logic [5:0]         r_e_pos;

    logic [10:0]        w_x, w_y, w_xp, w_xm, w_yp, w_ym;
    logic [10:0]        w_padl, w_padr, w_srv_sum;
    logic [9:0]         w_serve_x;
    logic signed [2:0]  w_spd, w_dx_n, w_dy_n;
    logic               w_left, w_right, w_top, w_paddle, w_pad_hit, w_lost;
    logic [10:0]        w_bx, w_bx_r, w_by, w_by_b;
    logic               w_side, w_tb, w_hit;
    logic [63:0]        w_clr;

    // All collision math is 11-bit unsigned; the low-side edge saturates at 0.
    assign w_x  = {1'b0, r_x};
    assign w_y  = {1'b0, r_y};
    assign w_xp = w_x + BS;
    assign w_yp = w_y + BS;
    assign w_xm = (w_x >= BS) ? w_x - BS : 11'd0;
    assign w_ym = (w_y >= BS) ? w_y - BS : 11'd0;

    assign w_spd = (r_erased >= 7'(SPEEDUP_N)) ? 3'sd2 : 3'sd1;

    assign w_padl    = {1'b0, i_paddle_x};
    assign w_padr    = w_padl + 11'(PADDLE_W);
    assign w_srv_sum = w_padl + 11'(PADDLE_W / 2);
    assign w_serve_x = (w_srv_sum > XMAX) ? XMAX[9:0] : w_srv_sum[9:0];

    assign w_left    = (r_x == 10'd0);
    assign w_right   = (w_x >= XMAX);
    assign w_top     = (w_y <= 11'd1);
    assign w_lost    = (w_y > 11'(SCREEN_H - BALL_SIZE));
    assign w_paddle  = (w_padl < w_x) && (w_x < w_padr) && (w_yp >= 11'(PADDLE_Y - 1)) &&
                       (w_ym < 11'(PADDLE_Y)) && (r_dy > 3'sd0);
    assign w_pad_hit = w_paddle && !w_top;

    // Directions are set to absolute values so a ball can never stick inside a wall.
    always_comb begin
        w_dx_n = r_dx;
        if (w_left) begin
            w_dx_n = w_spd;
        end else if (w_right) begin
            w_dx_n = -w_spd;
        end
        w_dy_n = r_dy;
        if (w_top) begin
            w_dy_n = w_spd;
        end else if (w_paddle) begin
            w_dy_n = -w_spd;
        end
    end

    assign w_bx   = 11'(SPACING_X) + 11'(r_col) * 11'(BLOCK_W + SPACING_X);
    assign w_bx_r = w_bx + 11'(BLOCK_W);
    assign w_by   = 11'(FIRST_ROW_Y) + 11'(r_row) * 11'(ROW_PITCH);
    assign w_by_b = w_by + 11'(BLOCK_H);

    assign w_side = (w_by < w_y) && (w_y < w_by_b) &&
                    (((w_xp > w_bx) && (w_xm < w_bx)) || ((w_xp > w_bx_r) && (w_xm < w_bx_r)));
    assign w_tb   = (w_bx < w_x) && (w_x < w_bx_r) &&
                    (((w_yp > w_by) && (w_ym < w_by)) || ((w_yp > w_by_b) && (w_ym < w_by_b)));
    assign w_hit  = r_bricks[r_k] && (w_side || w_tb);
    assign w_clr  = r_bricks & ~(64'd1 << r_k);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= StServe;
            r_x      <= RESET_X;
            r_y      <= SERVE_Y;
            r_dx     <= '0;
            r_dy     <= '0;
            r_erased <= '0;
            r_lives  <= 2'(LIVES);
            r_bricks <= ALL_BRICKS;
            r_k      <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_erase  <= 1'b0;
            r_e_pos  <= '0;
            r_snd1   <= 1'b0;
            r_snd2   <= 1'b0;
            r_win    <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_erase <= 1'b0;
            r_snd1  <= 1'b0;
            r_snd2  <= 1'b0;
            unique case (r_state)
                StServe: begin
                    if (i_tick) begin
                        r_x <= w_serve_x;
                        r_y <= SERVE_Y;
                        if (i_serve) begin
                            r_dx    <= -w_spd;
                            r_dy    <= -w_spd;
                            r_state <= StMove;
                        end
                    end
                end
                StMove: begin
                    if (i_tick) begin
                        if (w_lost) begin
                            r_snd2  <= 1'b1;
                            r_lives <= r_lives - 2'd1;
                            if (r_lives == 2'd1) begin
                                r_state <= StOver;
                                r_over  <= 1'b1;
                            end else begin
                                r_state <= StServe;
                            end
                        end else begin
                            r_dx    <= w_dx_n;
                            r_dy    <= w_dy_n;
                            r_x     <= r_x + {{7{w_dx_n[2]}}, w_dx_n};
                            r_y     <= r_y + {{7{w_dy_n[2]}}, w_dy_n};
                            r_snd1  <= w_left || w_right || w_top;
                            r_snd2  <= w_pad_hit;
                            r_k     <= '0;
                            r_row   <= '0;
                            r_col   <= '0;
                            r_state <= StScan;
                        end
                    end
                end
                StScan: begin
                    if (w_hit) begin
                        if (w_side) r_dx <= -r_dx;
                        if (w_tb) r_dy <= -r_dy;
                        r_bricks <= w_clr;
                        r_erase  <= 1'b1;
                        r_e_pos  <= r_k;
                        r_snd1   <= 1'b1;
                        if (r_erased < 7'(SPEEDUP_N)) r_erased <= r_erased + 7'd1;
                        if (w_clr == 64'd0) begin
                            r_state <= StWin;
                            r_win   <= 1'b1;
                        end else begin
                            r_state <= StMove;
                        end
                    end else if (r_k == 6'(NBRICKS - 1)) begin
                        if (r_bricks == 64'd0) begin
                            r_state <= StWin;
                            r_win   <= 1'b1;
                        end else begin
                            r_state <= StMove;
                        end
                    end else begin
                        r_k <= r_k + 6'd1;
                        if (r_col == 6'(COLS - 1)) begin
                            r_col <= '0;
                            r_row <= r_row + 6'd1;
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end
                StWin, StOver: ;
                default: r_state <= StServe;
            endcase
        end
    end

    assign o_x_out        = r_x;
    assign o_y_out        = r_y;
    assign o_erase_enable = r_erase;
    assign o_e_pos        = r_e_pos;
    assign o_play_sound1  = r_snd1;
    assign o_play_sound2  = r_snd2;
    assign o_lives        = r_lives;
    assign o_win          = r_win;
    assign o_game_over    = r_over;
endmodule

// File: tb/tb_ball_engine.sv
// Randomised bench for ball_engine: a game-level reference model predicts each tick's outcome
// into queues; an independent monitor compares them against what the DUT presents.
module tb_ball_engine;
    localparam int W = 640, H = 480, BS = 7, COLS = 5, NB = 10;
    localparam int BW = 80, BH = 30, SX = 40, FY = 40, RP = 50;
    localparam int PW = 100, PY = 440, LIV = 3, SPN = 4;
    localparam int TICK_GAP = 14;
    localparam int TICK_BUDGET = 5500;
    localparam int GAME_LIMIT = 1500;
    localparam int M_SERVE = 0, M_MOVE = 1, M_WIN = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_x = '0;
    logic [9:0] x_out, y_out;
    logic       erase_enable, play_sound1, play_sound2, win, game_over;
    logic [5:0] e_pos;
    logic [1:0] lives;

    ball_engine dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_tick        (tick),
        .i_serve       (serve),
        .i_paddle_x    (paddle_x),
        .o_x_out       (x_out),
        .o_y_out       (y_out),
        .o_erase_enable(erase_enable),
        .o_e_pos       (e_pos),
        .o_play_sound1 (play_sound1),
        .o_play_sound2 (play_sound2),
        .o_lives       (lives),
        .o_win         (win),
        .o_game_over   (game_over)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due; int x; int y; int lives; bit s1; bit s2; bit over; bit win;
    } pos_rec_t;
    typedef struct {
        int due; int pos; bit win;
    } ers_rec_t;

    pos_rec_t pos_q[$];
    ers_rec_t ers_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Game-level reference model.
    int m_mode, m_x, m_y, m_dx, m_dy, m_lives, m_erased;
    bit m_win, m_over;
    bit m_active[NB];

    function automatic int spd();
        return (m_erased >= SPN) ? 2 : 1;
    endfunction

    function automatic int sat0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit straddles(input int c, input int edge_v);
        return (c + BS > edge_v) && (sat0(c - BS) < edge_v);
    endfunction

    task automatic model_reset();
        m_mode = M_SERVE; m_x = 270; m_y = 430; m_dx = 0; m_dy = 0;
        m_lives = LIV; m_erased = 0; m_win = 0; m_over = 0;
        for (int k = 0; k < NB; k++) m_active[k] = 1'b1;
    endtask

    task automatic model_tick(input int px, input bit srv, input int tcyc);
        bit s1, s2, any;
        pos_rec_t pr;
        s1 = 0; s2 = 0;
        case (m_mode)
            M_SERVE: begin
                m_x = px + PW / 2;
                if (m_x > W - BS) m_x = W - BS;
                m_y = 430;
                if (srv) begin
                    m_dx = -spd(); m_dy = -spd(); m_mode = M_MOVE;
                end
            end
            M_MOVE: begin
                if (m_y > H - BS) begin
                    m_lives--; s2 = 1;
                    if (m_lives == 0) begin
                        m_mode = M_OVER; m_over = 1;
                    end else begin
                        m_mode = M_SERVE;
                    end
                end else begin
                    if (m_x <= 0) begin m_dx = spd(); s1 = 1; end
                    else if (m_x >= W - BS) begin m_dx = -spd(); s1 = 1; end
                    if (m_y <= 1) begin
                        m_dy = spd(); s1 = 1;
                    end else if (px < m_x && m_x < px + PW && m_y + BS >= PY - 1 &&
                                 sat0(m_y - BS) < PY && m_dy > 0) begin
                        m_dy = -spd(); s2 = 1;
                    end
                    m_x = (m_x + m_dx) & 1023;
                    m_y = (m_y + m_dy) & 1023;
                    for (int k = 0; k < NB; k++) begin
                        if (m_active[k]) begin
                            int bx, by;
                            bit side, tb;
                            ers_rec_t er;
                            bx = SX + (k % COLS) * (BW + SX);
                            by = FY + (k / COLS) * RP;
                            side = (by < m_y) && (m_y < by + BH) &&
                                   (straddles(m_x, bx) || straddles(m_x, bx + BW));
                            tb = (bx < m_x) && (m_x < bx + BW) &&
                                 (straddles(m_y, by) || straddles(m_y, by + BH));
                            if (side || tb) begin
                                if (side) m_dx = -m_dx;
                                if (tb) m_dy = -m_dy;
                                m_active[k] = 0;
                                m_erased++;
                                any = 0;
                                for (int j = 0; j < NB; j++) any |= m_active[j];
                                if (!any) begin m_win = 1; m_mode = M_WIN; end
                                er.due = tcyc + 2 + k; er.pos = k; er.win = m_win;
                                ers_q.push_back(er);
                                break;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
        pr.due = tcyc + 1; pr.x = m_x; pr.y = m_y; pr.lives = m_lives;
        pr.s1 = s1; pr.s2 = s2; pr.over = m_over; pr.win = m_win;
        pos_q.push_back(pr);
    endtask

    // Monitor: pulses are checked every cycle; erasures are popped when the DUT raises erase.
    initial begin
        bit p_due, e_due, exp_s1, exp_s2;
        pos_rec_t pr;
        ers_rec_t er;
        forever begin
            @(negedge clk);
            p_due = (pos_q.size() > 0) && (pos_q[0].due == cyc);
            e_due = (ers_q.size() > 0) && (ers_q[0].due == cyc);
            exp_s1 = e_due || (p_due && pos_q[0].s1);
            exp_s2 = p_due && pos_q[0].s2;
            check("play_sound1", 32'(play_sound1), 32'(exp_s1));
            check("play_sound2", 32'(play_sound2), 32'(exp_s2));
            if (erase_enable) begin
                if (ers_q.size() == 0) begin
                    check("erase_unexpected", 32'(erase_enable), 32'd0);
                end else begin
                    er = ers_q.pop_front();
                    check("erase_cycle", 32'(cyc), 32'(er.due));
                    check("e_pos", 32'(e_pos), 32'(er.pos));
                    check("win_at_erase", 32'(win), 32'(er.win));
                end
            end else if (ers_q.size() > 0 && ers_q[0].due <= cyc) begin
                er = ers_q.pop_front();
                check("erase_missing", 32'(erase_enable), 32'd1);
            end
            if (p_due) begin
                pr = pos_q.pop_front();
                check("x_out", 32'(x_out), 32'(pr.x));
                check("y_out", 32'(y_out), 32'(pr.y));
                check("lives", 32'(lives), 32'(pr.lives));
                check("game_over", 32'(game_over), 32'(pr.over));
                check("win", 32'(win), 32'(pr.win));
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0; tick = 1'b0; serve = 1'b0;
        pos_q.delete();
        ers_q.delete();
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_x", 32'(x_out), 32'd270);
        check("rst_y", 32'(y_out), 32'd430);
        check("rst_lives", 32'(lives), 32'(LIV));
        check("rst_erase", 32'(erase_enable), 32'd0);
        check("rst_e_pos", 32'(e_pos), 32'd0);
        check("rst_win", 32'(win), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
    endtask

    task automatic issue_tick(input int px, input bit srv);
        paddle_x = 10'(px); serve = srv; tick = 1'b1;
        model_tick(px, srv, cyc);
        @(negedge clk);
        tick = 1'b0; serve = 1'b0;
    endtask

    task automatic tick_gap(input int px, input bit srv);
        issue_tick(px, srv);
        repeat (TICK_GAP - 1) @(negedge clk);
    endtask

    initial begin
        int total, game_ticks, px, t;
        bit miss, srv;
        total = 0; game_ticks = 0; miss = 0;
        @(negedge clk);
        do_reset();
        tick_gap(200, 0);
        tick_gap(200, 1);
        repeat (5) tick_gap(200, 0);
        while (total < TICK_BUDGET) begin
            if (m_mode == M_WIN || m_mode == M_OVER) begin
                repeat (3) tick_gap($urandom_range(0, 600), 1'($urandom_range(0, 1)));
                total += 3;
                do_reset();
                game_ticks = 0;
            end else if (game_ticks >= GAME_LIMIT && m_mode == M_MOVE) begin
                // Reset lands while the brick scan of this tick is still running.
                issue_tick(m_x, 0);
                total++;
                do_reset();
                game_ticks = 0;
            end else begin
                srv = 0;
                if (m_mode == M_SERVE) begin
                    px = $urandom_range(0, 700);
                    srv = ($urandom_range(0, 3) == 0);
                    miss = ($urandom_range(0, 3) == 0);
                end else if (miss) begin
                    px = (m_x + 300) % 640;
                end else begin
                    t = m_x - 50 + int'($urandom_range(0, 60)) - 30;
                    px = (t < 0) ? 0 : ((t > 923) ? 923 : t);
                end
                tick_gap(px, srv);
                total++;
                game_ticks++;
            end
        end
        repeat (20) @(negedge clk);
        check("queues_drained", 32'(pos_q.size() + ers_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
